// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - Shared Hack timing defaults and sequencer state encoding
package hack_pkg;

  localparam int HACK_HALF_PERIOD = 25;
  localparam int HACK_WRITE_COUNT = 10;

  typedef enum logic [1:0] {
    SEQ_RESET_HOLD = 2'd0,
    SEQ_RUN        = 2'd1,
    SEQ_HALTED     = 2'd2,
    SEQ_STEP       = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - Two-flop synchroniser with rising-edge pulse
module sync_edge_detect (
  input  logic CLK_100MHz,
  input  logic RESET_N,
  input  logic async_in,
  output logic sync_level,
  output logic rise
);

  logic meta;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta   <= async_in;
      sync_q <= meta;
      prev_q <= sync_q;
    end
  end

  assign sync_level = sync_q;
  assign rise       = sync_q & ~prev_q;

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - Hack CPU clock/reset sequencer with run/halt/step; breakpoint under CPU_SEQ_BREAKPOINT_EN
module cpu_sequencer
  import hack_pkg::*;
#(
  parameter int HALF_PERIOD  = HACK_HALF_PERIOD,
  parameter int WRITE_COUNT  = HACK_WRITE_COUNT,
  parameter int RESET_CYCLES = 2
) (
  input  logic        CLK_100MHz,
  input  logic        RESET_N,
  input  logic        RUN,
  input  logic        STEP,
  input  logic [15:0] PC,
`ifdef CPU_SEQ_BREAKPOINT_EN
  input  logic        BP_EN,
  input  logic [15:0] BP_ADDR,
`endif
  output logic        CLK_CPU,
  output logic [31:0] CLK_COUNT,
  output logic        WRITE_STROBE,
  output logic        CPU_RESET,
  output logic        HALTED,
  output logic        BP_HIT,
  output logic [31:0] CYCLE_COUNT
);

  localparam logic [31:0] LAST_COUNT   = 32'(HALF_PERIOD - 1);
  localparam logic [31:0] STROBE_COUNT = 32'(WRITE_COUNT);
  localparam logic [31:0] LAST_RESET   = 32'(RESET_CYCLES - 1);

  seq_state_t  state, state_d;
  logic        clk_cpu_d, write_strobe_d, cpu_reset_d, halted_d;
  logic [31:0] clk_count_d, cycle_count_d;
  logic [31:0] reset_cnt, reset_cnt_d;
  logic        run_sync, run_rise_unused;
  logic        step_rise, step_level_unused;
  logic        advance, boundary;
  logic        bp_match, bp_lock_active, bp_halt, enter_run, enter_step;

  sync_edge_detect u_step_sync (
    .CLK_100MHz (CLK_100MHz),
    .RESET_N    (RESET_N),
    .async_in   (STEP),
    .sync_level (step_level_unused),
    .rise       (step_rise)
  );

  sync_edge_detect u_run_sync (
    .CLK_100MHz (CLK_100MHz),
    .RESET_N    (RESET_N),
    .async_in   (RUN),
    .sync_level (run_sync),
    .rise       (run_rise_unused)
  );

`ifdef CPU_SEQ_BREAKPOINT_EN
  logic bp_lock;

  assign bp_match       = BP_EN && (PC == BP_ADDR);
  assign bp_lock_active = bp_lock;

  // A breakpoint halt wins over the clears so the lock survives its own boundary.
  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      bp_lock <= 1'b0;
      BP_HIT  <= 1'b0;
    end else if (bp_halt) begin
      bp_lock <= 1'b1;
      BP_HIT  <= 1'b1;
    end else begin
      if (!run_sync || enter_step) bp_lock <= 1'b0;
      if (enter_run || enter_step) BP_HIT <= 1'b0;
    end
  end
`else
  logic unused_pc;

  assign unused_pc      = ^PC;
  assign bp_match       = 1'b0;
  assign bp_lock_active = 1'b0;
  assign BP_HIT         = 1'b0;
`endif

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= SEQ_RESET_HOLD;
      CLK_CPU      <= 1'b0;
      CLK_COUNT    <= '0;
      WRITE_STROBE <= 1'b0;
      CPU_RESET    <= 1'b1;
      HALTED       <= 1'b0;
      CYCLE_COUNT  <= '0;
      reset_cnt    <= '0;
    end else begin
      state        <= state_d;
      CLK_CPU      <= clk_cpu_d;
      CLK_COUNT    <= clk_count_d;
      WRITE_STROBE <= write_strobe_d;
      CPU_RESET    <= cpu_reset_d;
      HALTED       <= halted_d;
      CYCLE_COUNT  <= cycle_count_d;
      reset_cnt    <= reset_cnt_d;
    end
  end

  always_comb begin
    state_d       = state;
    clk_cpu_d     = CLK_CPU;
    clk_count_d   = CLK_COUNT;
    cycle_count_d = CYCLE_COUNT;
    cpu_reset_d   = CPU_RESET;
    halted_d      = HALTED;
    reset_cnt_d   = reset_cnt;
    bp_halt       = 1'b0;
    enter_run     = 1'b0;
    enter_step    = 1'b0;

    advance  = (state != SEQ_HALTED);
    boundary = advance && CLK_CPU && (CLK_COUNT == LAST_COUNT);

    if (advance) begin
      if (CLK_COUNT == LAST_COUNT) begin
        clk_count_d = '0;
        clk_cpu_d   = ~CLK_CPU;
      end else begin
        clk_count_d = CLK_COUNT + 32'd1;
      end
    end
    if (boundary) cycle_count_d = CYCLE_COUNT + 32'd1;

    // Strobe is registered, so it is decoded from the phase being entered.
    write_strobe_d = advance && clk_cpu_d && (clk_count_d == STROBE_COUNT);

    case (state)
      SEQ_RESET_HOLD: begin
        if (boundary) begin
          if (reset_cnt == LAST_RESET) begin
            cpu_reset_d = 1'b0;
            if (run_sync) begin
              state_d   = SEQ_RUN;
              enter_run = 1'b1;
            end else begin
              state_d  = SEQ_HALTED;
              halted_d = 1'b1;
            end
          end else begin
            reset_cnt_d = reset_cnt + 32'd1;
          end
        end
      end
      SEQ_RUN: begin
        if (boundary && (!run_sync || bp_match)) begin
          state_d  = SEQ_HALTED;
          halted_d = 1'b1;
          bp_halt  = bp_match;
        end
      end
      SEQ_HALTED: begin
        if (step_rise) begin
          state_d    = SEQ_STEP;
          halted_d   = 1'b0;
          enter_step = 1'b1;
        end else if (run_sync && !bp_lock_active) begin
          state_d   = SEQ_RUN;
          halted_d  = 1'b0;
          enter_run = 1'b1;
        end
      end
      SEQ_STEP: begin
        if (boundary) begin
          state_d  = SEQ_HALTED;
          halted_d = 1'b1;
        end
      end
      default: state_d = SEQ_RESET_HOLD;
    endcase
  end

endmodule
